// File: rtl/common_pkg.sv
// Machine-width types shared across the pipeline.
package common;
  localparam int XLEN = 64;
  typedef logic [31:0]     u32;
  typedef logic [XLEN-1:0] u64;
endpackage

// File: rtl/pipes_pkg.sv
// Decoder control encoding and RV64 opcode/funct field constants.
package pipes;
  typedef enum logic [2:0] {
    OP_NONE, OP_RTYPE, OP_ITYPE, OP_STYPE, OP_BTYPE, OP_UTYPE, OP_JTYPE
  } op_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
    ALU_LS, ALU_RS, ALU_SRS, ALU_PASSB
  } alufunc_t;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } branch_t;

  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  localparam logic [1:0] MEM_NONE = 2'd0, MEM_RD = 2'd1, MEM_WR = 2'd2;

  typedef struct packed {
    op_t        op;
    alufunc_t   alufunc;
    logic       regWrite;
    logic       selectA;    // 1 = PC instead of rs1
    logic       selectB;    // 1 = immediate instead of rs2
    logic [1:0] wbSelect;
    logic [1:0] memRw;
    branch_t    branch;
    logic       pcSrc;      // unconditional jump
    logic       pcTarget;   // 1 = rs1 + imm, 0 = pc + imm
    logic       extAluOut;  // sign-extend low 32 bits of ALU result
  } control_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;

  localparam logic [5:0] F6_NORM  = 6'b000000;
  localparam logic [5:0] F6_ARITH = 6'b010000;
  localparam logic [6:0] F7_NORM  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  function automatic alufunc_t base_alu(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_LS;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_RS;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/instr_decode.sv
// Combinational RV64 decoder: raw instruction -> control word plus illegal flag.
// Illegal encodings produce an all-zero control word.
module instr_decode
  import common::*, pipes::*;
(
  input  u32       raw_instr,
  input  logic     enable_w,
  output control_t ctl,
  output logic     illegal
);
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [5:0] funct6;
  logic       is_w, alt, bad;
  control_t   c;
  logic       unused_fields;

  assign opcode        = raw_instr[6:0];
  assign funct3        = raw_instr[14:12];
  assign funct7        = raw_instr[31:25];
  assign funct6        = raw_instr[31:26];
  assign unused_fields = ^{raw_instr[24:15], raw_instr[11:7]};

  always_comb begin
    c    = '0;
    bad  = 1'b0;
    is_w = (opcode == OPC_OP_IMM_32) || (opcode == OPC_OP_32);
    alt  = (funct7 == F7_ALT);
    case (opcode)
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        c.op        = OP_ITYPE;
        c.regWrite  = 1'b1;
        c.selectB   = 1'b1;
        c.extAluOut = is_w;
        c.alufunc   = base_alu(funct3);
        if (funct3 == F3_SLL) bad = (funct6 != F6_NORM);
        else if (funct3 == F3_SR) begin
          if (funct6 == F6_ARITH) c.alufunc = ALU_SRS;
          else bad = (funct6 != F6_NORM);
        end
        else bad = is_w && (funct3 != F3_ADD);
      end
      OPC_OP, OPC_OP_32: begin
        c.op        = OP_RTYPE;
        c.regWrite  = 1'b1;
        c.extAluOut = is_w;
        c.alufunc   = base_alu(funct3);
        if (alt) begin
          if (funct3 == F3_ADD) c.alufunc = ALU_SUB;
          else if (funct3 == F3_SR) c.alufunc = ALU_SRS;
          else bad = 1'b1;
        end
        else if (funct7 != F7_NORM) bad = 1'b1;
        if (is_w && !(funct3 inside {F3_ADD, F3_SLL, F3_SR})) bad = 1'b1;
      end
      OPC_LUI: begin
        c.op = OP_UTYPE; c.alufunc = ALU_PASSB; c.regWrite = 1'b1; c.selectB = 1'b1;
      end
      OPC_AUIPC: begin
        c.op = OP_UTYPE; c.alufunc = ALU_ADD; c.regWrite = 1'b1;
        c.selectA = 1'b1; c.selectB = 1'b1;
      end
      OPC_JAL: begin
        c.op = OP_JTYPE; c.regWrite = 1'b1; c.wbSelect = WB_PC4; c.pcSrc = 1'b1;
      end
      OPC_JALR: begin
        c.op = OP_JTYPE; c.regWrite = 1'b1; c.selectB = 1'b1; c.wbSelect = WB_PC4;
        c.pcSrc = 1'b1; c.pcTarget = 1'b1;
      end
      OPC_BRANCH: begin
        c.op = OP_BTYPE; c.alufunc = ALU_SUB;
        case (funct3)
          F3_BEQ:  c.branch = BR_EQ;
          F3_BNE:  c.branch = BR_NE;
          F3_BLT:  c.branch = BR_LT;
          F3_BGE:  c.branch = BR_GE;
          F3_BLTU: c.branch = BR_LTU;
          F3_BGEU: c.branch = BR_GEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        c.op = OP_ITYPE; c.alufunc = ALU_ADD; c.regWrite = 1'b1; c.selectB = 1'b1;
        c.wbSelect = WB_MEM; c.memRw = MEM_RD;
        bad = (funct3 != F3_DWORD);
      end
      OPC_STORE: begin
        c.op = OP_STYPE; c.alufunc = ALU_ADD; c.selectB = 1'b1; c.memRw = MEM_WR;
        bad = (funct3 != F3_DWORD);
      end
      default: bad = 1'b1;
    endcase
    if (is_w && !enable_w) bad = 1'b1;
    ctl     = bad ? '0 : c;
    illegal = bad;
  end
endmodule

// File: rtl/decode_buffer.sv
// Instruction FIFO feeding a decoded output register; 2-edge latency, 1/cycle throughput.
// in_ready drops when the FIFO is full or on flush/reset; output holds while out_ready is low.
module decode_buffer
  import common::*, pipes::*;
#(
  parameter int DEPTH    = 4,
  parameter int ENABLE_W = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  u64                     in_pc,
  input  u32                     in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output u64                     out_pc,
  output u32                     out_instr,
  output control_t               out_ctl,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic        EN_W = (ENABLE_W != 0);

  typedef struct packed {
    u64 pc;
    u32 instr;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           push, pop;
  control_t       head_ctl;
  logic           head_ill;

  assign in_ready = !reset && !flush && (count < FULL);
  assign push     = in_valid && in_ready;
  // Refill the output register whenever it is empty or being consumed.
  assign pop      = (count != '0) && (!out_valid || out_ready);

  instr_decode u_decode (
    .raw_instr (mem[rd_ptr].instr),
    .enable_w  (EN_W),
    .ctl       (head_ctl),
    .illegal   (head_ill)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_ctl     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        out_valid   <= 1'b1;
        out_pc      <= mem[rd_ptr].pc;
        out_instr   <= mem[rd_ptr].instr;
        out_ctl     <= head_ctl;
        out_illegal <= head_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: doc/decode_buffer.md
DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter ENABLE_W, default 1, 1 = decode RV64 W-ops (OP-IMM-32/OP-32), 0 = flag them illegal.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port flush  in  1  discard all buffered and output instructions.
REQ-007 SHALL have port in_valid  in  1  fetch offers an instruction.
REQ-008 SHALL have port in_ready  out  1  buffer accepts this cycle.
REQ-009 SHALL have port in_pc  in  64  PC of offered instruction.
REQ-010 SHALL have port in_instr  in  32  raw instruction.
REQ-011 SHALL have port out_valid  out  1  decoded instruction presented to execute.
REQ-012 SHALL have port out_ready  in  1  execute consumes this cycle.
REQ-013 SHALL have port out_pc  out  64  PC of presented instruction.
REQ-014 SHALL have port out_instr  out  32  raw presented instruction.
REQ-015 SHALL have port out_ctl  out  control_t  decoded control (op, alufunc, regWrite, selectA, selectB, wbSelect, memRw, branch, pcSrc, pcTarget, extAluOut).
REQ-016 SHALL have port out_illegal  out  1  presented instruction is unsupported/reserved.
REQ-017 SHALL have port count  out  $clog2(DEPTH)+1  FIFO occupancy, output register excluded.

Function
REQ-018 SHALL accept on in_valid&&in_ready; in_ready = (count<DEPTH) && !flush, independent of out_ready.
REQ-019 SHALL hold a single output register; it loads the FIFO head (decoded) when empty or when out_valid&&out_ready, in the same edge the head is popped.
REQ-020 SHALL have latency 2 edges: accepted at edge t with empty buffer -> out_valid high after edge t+1; throughput one instruction/cycle sustained.
REQ-021 SHALL keep out_pc/out_instr/out_ctl/out_illegal stable while out_valid&&!out_ready.
REQ-022 SHALL preserve program order; push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 SHALL decode OP-IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH(6 funct3), LOAD(ld), STORE(sd), and OP-IMM-32/OP-32 when ENABLE_W=1, with same control encoding as the existing single-issue decoder.
REQ-024 SHALL set extAluOut=1 for all W-ops; shifts select LS/RS/SRS by funct3 and funct6 (SRAI/SRAIW funct6=010000).
REQ-025 SHALL flag illegal (out_ctl all zero, out_illegal=1) for: unknown opcode; OP funct7 not 0000000/0100000; SUB only with funct3=000; shift funct6 not 000000/010000; W-op with ENABLE_W=0; load/store funct3 != 011.
REQ-026 SHALL on flush: next edge count=0, out_valid=0; in_valid during flush dropped; flush overrides simultaneous push/pop.

Reset
REQ-027 SHALL on reset: count=0, pointers=0, out_valid=0, out_pc=0, out_instr=0, out_ctl='0, out_illegal=0; in_ready=0 during reset cycle.
REQ-028 SHALL on reset mid-operation discard all entries; first accepted instruction after reset follows REQ-020 latency.

Structure
REQ-029 SHALL place control_t, op/alufunc/branch enums, opcode/funct3/funct6/funct7 constants in package pipes; XLEN/u32/u64 in common.
REQ-030 SHALL implement decode as one combinational sub-module instr_decode (raw_instr, enable_w -> control_t, illegal); FIFO and output register in decode_buffer.

Verification
REQ-031 SHALL test: 0x00500093 (addi x1,x0,5) -> 2 edges later out_valid=1, op=ITYPE, alufunc=ADD, selectB=1, regWrite=1.
REQ-032 SHALL test: out_ready=0, offer 6 instrs, DEPTH=4 -> 5 accepted, count=4, in_ready=0; then out_ready=1 -> drained in order, one per cycle.
REQ-033 SHALL test: 0x4010d093 (srai) -> alufunc=SRS; 0x8010d093 -> out_illegal=1, out_ctl=0; 0x00000000 -> illegal.
REQ-034 SHALL test: ENABLE_W=0, 0x0010809b (addiw) -> illegal; ENABLE_W=1 -> extAluOut=1, selectB=1.
REQ-035 SHALL test: count=3, out_valid=1, flush with in_valid=1 -> next cycle count=0, out_valid=0, offered instruction never appears.
REQ-036 SHALL test: reset asserted with count=2 -> next cycle all outputs per REQ-027; 0x40208033 afterwards -> alufunc=SUB, op=RTYPE.
